// File: rtl/uart_rx_check_fifo.sv
// uart_rx_check_fifo
//   Qualifies each frame completed by the UART RX FSM against its parity and
//   stop error flags. Accepted frames go into a first-word-fall-through FIFO
//   with a valid/ready output handshake. The block also keeps saturating
//   per-type error counters and a sticky overrun flag.
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   RX_CHECK_EN   in   strobe: frame complete, flags and data valid
//   parity_error  in   parity error of the current frame
//   stop_error    in   stop-bit error of the current frame
//   P_DATA_REG    in   received data word
//   DATA_READY    in   consumer takes the head entry this cycle
//   DATA_VALID    out  FIFO not empty, head entry presented
//   P_DATA_OUT    out  head entry data
//   P_ERR_OUT     out  head entry tags {stop_error, parity_error}
//   FIFO_COUNT    out  number of occupied entries (0..FIFO_DEPTH)
//   OVERRUN       out  sticky: a frame was lost to a full FIFO
//   PAR_ERR_CNT   out  saturating parity error count
//   STOP_ERR_CNT  out  saturating stop error count
//   ERR_CLR       in   clears OVERRUN and both counters
module uart_rx_check_fifo #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned CNT_WIDTH     = 8,
  parameter bit          DROP_ON_ERROR = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          RX_CHECK_EN,
  input  logic                          parity_error,
  input  logic                          stop_error,
  input  logic [DATA_WIDTH-1:0]         P_DATA_REG,
  input  logic                          DATA_READY,
  output logic                          DATA_VALID,
  output logic [DATA_WIDTH-1:0]         P_DATA_OUT,
  output logic [1:0]                    P_ERR_OUT,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
  output logic                          OVERRUN,
  output logic [CNT_WIDTH-1:0]          PAR_ERR_CNT,
  output logic [CNT_WIDTH-1:0]          STOP_ERR_CNT,
  input  logic                          ERR_CLR
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = PTR_W + 1;
  localparam int unsigned ENTRY_W = DATA_WIDTH + 2;
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_WIDTH'(1);
    end
  endfunction

  // Storage: each entry is {stop_error, parity_error, data}.
  logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 valid_q, valid_d;
  logic [ENTRY_W-1:0]   head_q, head_d;
  logic                 overrun_q, overrun_d;
  logic [CNT_WIDTH-1:0] par_cnt_q, par_cnt_d;
  logic [CNT_WIDTH-1:0] stop_cnt_q, stop_cnt_d;

  logic                 frame_err_s;
  logic                 wr_req_s;
  logic                 pop_s;
  logic                 full_s;
  logic                 wr_en_s;
  logic                 ovr_evt_s;
  logic                 par_evt_s;
  logic                 stop_evt_s;
  logic [ENTRY_W-1:0]   wr_entry_s;

  // Frame qualification and FIFO write/pop decisions.
  always_comb begin
    frame_err_s = parity_error | stop_error;
    par_evt_s   = RX_CHECK_EN & parity_error;
    stop_evt_s  = RX_CHECK_EN & stop_error;
    pop_s       = valid_q & DATA_READY;
    full_s      = (count_q == COUNT_FULL);
    wr_req_s    = 1'b0;
    wr_entry_s  = {2'b00, P_DATA_REG};
    if (DROP_ON_ERROR) begin
      wr_req_s   = RX_CHECK_EN & ~frame_err_s;
      wr_entry_s = {2'b00, P_DATA_REG};
    end else begin
      wr_req_s   = RX_CHECK_EN;
      wr_entry_s = {stop_error, parity_error, P_DATA_REG};
    end
    // A full FIFO can still take a frame when the head leaves in the same cycle.
    wr_en_s   = wr_req_s & (~full_s | pop_s);
    ovr_evt_s = wr_req_s & full_s & ~pop_s;
  end

  // Pointer, occupancy and head-entry next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = {ENTRY_W{1'b0}};
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != {CW{1'b0}});
    // The word written this edge becomes the head when it lands at the new read
    // pointer (FIFO empty, or draining its last entry), so bypass the memory.
    if (!valid_d) begin
      head_d = {ENTRY_W{1'b0}};
    end else if (wr_en_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = wr_entry_s;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Error counters and overrun flag; a same-cycle event survives ERR_CLR.
  always_comb begin
    par_cnt_d  = par_cnt_q;
    stop_cnt_d = stop_cnt_q;
    overrun_d  = overrun_q;
    if (ERR_CLR) begin
      par_cnt_d  = par_evt_s  ? CNT_WIDTH'(1) : {CNT_WIDTH{1'b0}};
      stop_cnt_d = stop_evt_s ? CNT_WIDTH'(1) : {CNT_WIDTH{1'b0}};
      overrun_d  = ovr_evt_s;
    end else begin
      par_cnt_d  = par_evt_s  ? sat_inc(par_cnt_q)  : par_cnt_q;
      stop_cnt_d = stop_evt_s ? sat_inc(stop_cnt_q) : stop_cnt_q;
      overrun_d  = overrun_q | ovr_evt_s;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CW{1'b0}};
      valid_q    <= 1'b0;
      head_q     <= {ENTRY_W{1'b0}};
      overrun_q  <= 1'b0;
      par_cnt_q  <= {CNT_WIDTH{1'b0}};
      stop_cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
      overrun_q  <= overrun_d;
      par_cnt_q  <= par_cnt_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  // FIFO storage write port; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_en_s) begin
      mem_q[wr_ptr_q] <= wr_entry_s;
    end
  end

  assign DATA_VALID   = valid_q;
  assign P_DATA_OUT   = head_q[DATA_WIDTH-1:0];
  assign P_ERR_OUT    = head_q[ENTRY_W-1:DATA_WIDTH];
  assign FIFO_COUNT   = count_q;
  assign OVERRUN      = overrun_q;
  assign PAR_ERR_CNT  = par_cnt_q;
  assign STOP_ERR_CNT = stop_cnt_q;

endmodule

// File: tb/tb_uart_rx_check_fifo.sv
// Directed bench for uart_rx_check_fifo. Instance dut drops errored frames
// (default parameters); instance dut_keep stores them with error tags. Both
// share the same stimulus.
module tb_uart_rx_check_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_check_en = 1'b0;
  logic       parity_error = 1'b0;
  logic       stop_error = 1'b0;
  logic [7:0] p_data_reg = 8'h00;
  logic       data_ready = 1'b0;
  logic       err_clr = 1'b0;

  logic       v1, o1;
  logic [7:0] d1, pc1, sc1;
  logic [1:0] e1;
  logic [2:0] c1;
  logic       v0, o0;
  logic [7:0] d0, pc0, sc0;
  logic [1:0] e0;
  logic [2:0] c0;

  int total = 0;
  int bad   = 0;

  uart_rx_check_fifo dut (
    .clk(clk), .rst(rst), .RX_CHECK_EN(rx_check_en), .parity_error(parity_error),
    .stop_error(stop_error), .P_DATA_REG(p_data_reg), .DATA_READY(data_ready),
    .DATA_VALID(v1), .P_DATA_OUT(d1), .P_ERR_OUT(e1), .FIFO_COUNT(c1),
    .OVERRUN(o1), .PAR_ERR_CNT(pc1), .STOP_ERR_CNT(sc1), .ERR_CLR(err_clr)
  );

  uart_rx_check_fifo #(.DROP_ON_ERROR(1'b0)) dut_keep (
    .clk(clk), .rst(rst), .RX_CHECK_EN(rx_check_en), .parity_error(parity_error),
    .stop_error(stop_error), .P_DATA_REG(p_data_reg), .DATA_READY(data_ready),
    .DATA_VALID(v0), .P_DATA_OUT(d0), .P_ERR_OUT(e0), .FIFO_COUNT(c0),
    .OVERRUN(o0), .PAR_ERR_CNT(pc0), .STOP_ERR_CNT(sc0), .ERR_CLR(err_clr)
  );

  always #5 clk = ~clk;

  // One clock edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame strobe lasting a single cycle.
  task automatic frame(input logic [7:0] d, input logic par, input logic stp);
    rx_check_en  = 1'b1;
    p_data_reg   = d;
    parity_error = par;
    stop_error   = stp;
    tick();
    rx_check_en  = 1'b0;
    parity_error = 1'b0;
    stop_error   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; data_ready = 1'b0; err_clr = 1'b0; rx_check_en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (v1 !== 1'b0)  begin bad++; $display("FAIL rst_valid got=%h exp=0", v1); end
    total++; if (d1 !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", d1); end
    total++; if (e1 !== 2'b00) begin bad++; $display("FAIL rst_err got=%b exp=00", e1); end
    total++; if (c1 !== 3'd0)  begin bad++; $display("FAIL rst_count got=%0d exp=0", c1); end
    total++; if (o1 !== 1'b0)  begin bad++; $display("FAIL rst_overrun got=%b exp=0", o1); end
    total++; if (pc1 !== 8'd0) begin bad++; $display("FAIL rst_parcnt got=%0d exp=0", pc1); end
    total++; if (sc1 !== 8'd0) begin bad++; $display("FAIL rst_stopcnt got=%0d exp=0", sc1); end
  endtask

  task automatic test_order();
    logic [7:0] exp_q [3];
    exp_q[0] = 8'hA1; exp_q[1] = 8'hB2; exp_q[2] = 8'hC3;
    do_reset();
    frame(8'hA1, 1'b0, 1'b0);
    total++; if (v1 !== 1'b1 || d1 !== 8'hA1) begin bad++; $display("FAIL latency got v=%b d=%h exp v=1 d=a1", v1, d1); end
    frame(8'hB2, 1'b0, 1'b0);
    frame(8'hC3, 1'b0, 1'b0);
    total++; if (c1 !== 3'd3) begin bad++; $display("FAIL order_count got=%0d exp=3", c1); end
    tick();
    total++; if (d1 !== 8'hA1) begin bad++; $display("FAIL order_hold got=%h exp=a1", d1); end
    data_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (v1 !== 1'b1 || d1 !== exp_q[i]) begin bad++; $display("FAIL order_pop%0d got v=%b d=%h exp v=1 d=%h", i, v1, d1, exp_q[i]); end
      tick();
    end
    data_ready = 1'b0;
    total++; if (v1 !== 1'b0 || c1 !== 3'd0) begin bad++; $display("FAIL order_empty got v=%b c=%0d exp v=0 c=0", v1, c1); end
  endtask

  task automatic test_errors();
    do_reset();
    frame(8'h55, 1'b1, 1'b0);
    frame(8'h66, 1'b0, 1'b1);
    total++; if (c1 !== 3'd0 || v1 !== 1'b0) begin bad++; $display("FAIL drop_count got c=%0d v=%b exp c=0 v=0", c1, v1); end
    total++; if (pc1 !== 8'd1 || sc1 !== 8'd1) begin bad++; $display("FAIL drop_cnts got p=%0d s=%0d exp p=1 s=1", pc1, sc1); end
    total++; if (c0 !== 3'd2) begin bad++; $display("FAIL keep_count got=%0d exp=2", c0); end
    total++; if (d0 !== 8'h55 || e0 !== 2'b01) begin bad++; $display("FAIL keep_head0 got d=%h e=%b exp d=55 e=01", d0, e0); end
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    total++; if (d0 !== 8'h66 || e0 !== 2'b10) begin bad++; $display("FAIL keep_head1 got d=%h e=%b exp d=66 e=10", d0, e0); end
    total++; if (pc0 !== 8'd1 || sc0 !== 8'd1) begin bad++; $display("FAIL keep_cnts got p=%0d s=%0d exp p=1 s=1", pc0, sc0); end
    frame(8'h77, 1'b1, 1'b1);
    total++; if (pc1 !== 8'd2 || sc1 !== 8'd2) begin bad++; $display("FAIL both_flags got p=%0d s=%0d exp p=2 s=2", pc1, sc1); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h02; exp_q[1] = 8'h03; exp_q[2] = 8'h04; exp_q[3] = 8'h06;
    do_reset();
    for (int i = 1; i <= 4; i++) frame(8'(i), 1'b0, 1'b0);
    total++; if (c1 !== 3'd4 || o1 !== 1'b0) begin bad++; $display("FAIL full_count got c=%0d o=%b exp c=4 o=0", c1, o1); end
    frame(8'h05, 1'b0, 1'b0);
    total++; if (c1 !== 3'd4 || o1 !== 1'b1 || d1 !== 8'h01) begin bad++; $display("FAIL overrun got c=%0d o=%b d=%h exp c=4 o=1 d=01", c1, o1, d1); end
    data_ready = 1'b1;
    frame(8'h06, 1'b0, 1'b0);
    data_ready = 1'b0;
    total++; if (c1 !== 3'd4 || o1 !== 1'b1) begin bad++; $display("FAIL full_pop got c=%0d o=%b exp c=4 o=1", c1, o1); end
    data_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (v1 !== 1'b1 || d1 !== exp_q[i]) begin bad++; $display("FAIL drain%0d got v=%b d=%h exp v=1 d=%h", i, v1, d1, exp_q[i]); end
      tick();
    end
    data_ready = 1'b0;
    total++; if (v1 !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", v1); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 255; i++) frame(8'h5A, 1'b1, 1'b0);
    total++; if (pc1 !== 8'd255) begin bad++; $display("FAIL cnt255 got=%0d exp=255", pc1); end
    for (int i = 0; i < 5; i++) frame(8'h5A, 1'b1, 1'b0);
    total++; if (pc1 !== 8'd255 || sc1 !== 8'd0) begin bad++; $display("FAIL sat got p=%0d s=%0d exp p=255 s=0", pc1, sc1); end
    for (int i = 0; i < 5; i++) frame(8'(8'h10 + i), 1'b0, 1'b0);
    total++; if (o1 !== 1'b1 || c1 !== 3'd4) begin bad++; $display("FAIL sat_ovr got o=%b c=%0d exp o=1 c=4", o1, c1); end
    err_clr = 1'b1;
    frame(8'h99, 1'b1, 1'b0);
    err_clr = 1'b0;
    total++; if (pc1 !== 8'd1 || o1 !== 1'b0) begin bad++; $display("FAIL clr_par got p=%0d o=%b exp p=1 o=0", pc1, o1); end
    total++; if (c1 !== 3'd4 || d1 !== 8'h10) begin bad++; $display("FAIL clr_fifo got c=%0d d=%h exp c=4 d=10", c1, d1); end
    err_clr = 1'b1;
    frame(8'h20, 1'b0, 1'b0);
    err_clr = 1'b0;
    total++; if (o1 !== 1'b1 || pc1 !== 8'd0) begin bad++; $display("FAIL clr_ovr got o=%b p=%0d exp o=1 p=0", o1, pc1); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    frame(8'h11, 1'b1, 1'b0);
    frame(8'h22, 1'b0, 1'b0);
    frame(8'h33, 1'b0, 1'b0);
    data_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    data_ready = 1'b0;
    total++; if (v1 !== 1'b0 || c1 !== 3'd0 || d1 !== 8'h00 || e1 !== 2'b00) begin bad++; $display("FAIL midrst_fifo got v=%b c=%0d d=%h e=%b exp all 0", v1, c1, d1, e1); end
    total++; if (o1 !== 1'b0 || pc1 !== 8'd0 || sc1 !== 8'd0) begin bad++; $display("FAIL midrst_flags got o=%b p=%0d s=%0d exp all 0", o1, pc1, sc1); end
    total++; if (v0 !== 1'b0 || c0 !== 3'd0) begin bad++; $display("FAIL midrst_keep got v=%b c=%0d exp v=0 c=0", v0, c0); end
    frame(8'h3C, 1'b0, 1'b0);
    total++; if (v1 !== 1'b1 || d1 !== 8'h3C || c1 !== 3'd1) begin bad++; $display("FAIL post_rst got v=%b d=%h c=%0d exp v=1 d=3c c=1", v1, d1, c1); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    data_ready = 1'b1;
    frame(8'hCC, 1'b0, 1'b0);
    total++; if (v1 !== 1'b1 || d1 !== 8'hCC || c1 !== 3'd1) begin bad++; $display("FAIL empty_wr got v=%b d=%h c=%0d exp v=1 d=cc c=1", v1, d1, c1); end
    frame(8'hDD, 1'b0, 1'b0);
    total++; if (v1 !== 1'b1 || d1 !== 8'hDD || c1 !== 3'd1) begin bad++; $display("FAIL one_wrpop got v=%b d=%h c=%0d exp v=1 d=dd c=1", v1, d1, c1); end
    tick();
    data_ready = 1'b0;
    total++; if (v1 !== 1'b0 || c1 !== 3'd0) begin bad++; $display("FAIL b2b_empty got v=%b c=%0d exp v=0 c=0", v1, c1); end
  endtask

  initial begin
    test_reset();
    test_order();
    test_errors();
    test_overrun();
    test_saturate();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
